// File: rtl/jtag_master_pkg.sv
// Shared encodings for the JTAG TAP master: FSM states and the fixed TMS
// walks used to move the remote TAP between Run-Test/Idle and the shift states.
package jtag_master_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_TLR   = 3'd0;
    localparam state_t ST_IDLE  = 3'd1;
    localparam state_t ST_PRE   = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_POST  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // TMS patterns are stored bit 0 first (bit 0 goes out on the first TCK)
    localparam logic [3:0] PRE_DR_TMS = 4'b0001;
    localparam logic [3:0] PRE_IR_TMS = 4'b0011;
    localparam int         PRE_DR_LEN = 3;
    localparam int         PRE_IR_LEN = 4;
    localparam logic [1:0] POST_TMS   = 2'b01;
    localparam int         POST_LEN   = 2;
    localparam int         TLR_LEN    = 6;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: toggles tck every CLK_DIV cycles while run is high and
// flags which toggle is a rising or falling TCK edge.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = run && (cnt == CW'(CLK_DIV - 1));
    assign rise = tick && !tck;
    assign fall = tick && tck;

    // Dropping run parks TCK low with a fresh count, so every scan starts alike
    always_ff @(posedge clk_i) begin
        if (rst_i || !run) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_tap_master.sv
// Fabric-side JTAG initiator: walks the remote 1149.1 TAP from Run-Test/Idle
// through one complete IR or DR scan per command and returns the captured TDO bits.
//
// state | meaning
// TLR   | TMS=1 for 5 TCKs then TMS=0 once, remote TAP ends in Run-Test/Idle
// IDLE  | remote TAP parked in Run-Test/Idle, TCK low, accepting commands
// PRE   | TMS walk from Run-Test/Idle into Shift-DR / Shift-IR
// SHIFT | one TCK per data bit, TMS=1 on the last bit
// POST  | TMS 1,0 through Update back to Run-Test/Idle
// DONE  | one cycle: pulse rsp_valid_o, publish captured data
module jtag_tap_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_tlr_i,
    input  logic               cmd_ir_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    state_t             state;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len;
    logic               is_tlr;
    logic               is_ir;
    logic [MAX_LEN-1:0] tx;
    logic [MAX_LEN-1:0] rx;
    logic [3:0]         pat;
    logic               run;
    logic               rise;
    logic               fall;
    logic [LEN_W-1:0]   len_sat;
    logic [LEN_W-1:0]   len_last;
    logic [LEN_W-1:0]   pre_last;

    assign run = (state == ST_TLR) || (state == ST_PRE) ||
                 (state == ST_SHIFT) || (state == ST_POST);
    assign cmd_ready_o = (state == ST_IDLE);
    assign len_sat  = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
    assign len_last = len - LEN_W'(1);
    assign pre_last = is_ir ? LEN_W'(PRE_IR_LEN - 1) : LEN_W'(PRE_DR_LEN - 1);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .run   (run),
        .tck   (tck_o),
        .rise  (rise),
        .fall  (fall)
    );

    // TMS/TDI change only on falling ticks, always carrying the value for the next TCK cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_TLR;
            idx         <= '0;
            len         <= '0;
            is_tlr      <= 1'b0;
            is_ir       <= 1'b0;
            tx          <= '0;
            rx          <= '0;
            pat         <= '0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tms_o <= 1'b0;
                    tdi_o <= 1'b0;
                    if (cmd_valid_i) begin
                        idx    <= '0;
                        is_tlr <= cmd_tlr_i;
                        is_ir  <= cmd_ir_i;
                        len    <= len_sat;
                        tx     <= cmd_data_i;
                        rx     <= '0;
                        if (cmd_tlr_i) begin
                            state <= ST_TLR;
                            tms_o <= 1'b1;
                        end else if (len_sat == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_PRE;
                            tms_o <= 1'b1;
                            pat   <= cmd_ir_i ? (PRE_IR_TMS >> 1) : (PRE_DR_TMS >> 1);
                        end
                    end
                end
                ST_TLR: begin
                    if (fall) begin
                        if (idx == LEN_W'(TLR_LEN - 1)) begin
                            tms_o <= 1'b0;
                            state <= is_tlr ? ST_DONE : ST_IDLE;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            tms_o <= (idx != LEN_W'(TLR_LEN - 2));
                        end
                    end
                end
                ST_PRE: begin
                    if (fall) begin
                        if (idx == pre_last) begin
                            state <= ST_SHIFT;
                            idx   <= '0;
                            tms_o <= (len == LEN_W'(1));
                            tdi_o <= tx[0];
                            tx    <= tx >> 1;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            tms_o <= pat[0];
                            pat   <= pat >> 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (rise && idx == LEN_W'(i))
                            rx[i] <= tdo_i;
                    end
                    if (fall) begin
                        if (idx == len_last) begin
                            state <= ST_POST;
                            idx   <= '0;
                            tms_o <= POST_TMS[0];
                            tdi_o <= 1'b0;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            tms_o <= ((idx + LEN_W'(1)) == len_last);
                            tdi_o <= tx[0];
                            tx    <= tx >> 1;
                        end
                    end
                end
                ST_POST: begin
                    if (fall) begin
                        if (idx == LEN_W'(POST_LEN - 1)) begin
                            state <= ST_DONE;
                            tms_o <= 1'b0;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            tms_o <= POST_TMS[1];
                        end
                    end
                end
                ST_DONE: begin
                    rsp_valid_o <= 1'b1;
                    if (!is_tlr)
                        rsp_data_o <= rx;
                    state <= ST_IDLE;
                end
                default: state <= ST_TLR;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: a behavioural 1149.1 TAP (10-bit IR, 32-bit DR)
// sits on the JTAG pins; expected responses go through a scoreboard queue.
module tb_jtag_tap_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int TPC     = 2 * CLK_DIV;

    localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4, T_E1DR = 5,
                   T_PDR = 6, T_E2DR = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11,
                   T_E1IR = 12, T_PIR = 13, T_E2IR = 14, T_UIR = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_tlr = 1'b0;
    logic               cmd_ir = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck, tms, tdi;
    logic               tdo = 1'b0;

    always #5 clk = ~clk;

    jtag_tap_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_tlr_i   (cmd_tlr),
        .cmd_ir_i    (cmd_ir),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
    );

    // ---------------- behavioural TAP ----------------
    int          tap_st = T_TLR;
    logic [31:0] dr_sh = '0, dr_cap = '0, dr_upd = '0;
    logic [9:0]  ir_sh = '0, ir_val = '0;
    int          nshift = 0, upd_cnt = 0, tck_rises = 0;
    logic        tms_q[$];
    logic        tdi_q[$];

    function automatic int tap_next(input int s, input logic t);
        case (s)
            T_TLR:  return t ? T_TLR  : T_RTI;
            T_RTI:  return t ? T_SDR  : T_RTI;
            T_SDR:  return t ? T_SIR  : T_CDR;
            T_CDR:  return t ? T_E1DR : T_SHDR;
            T_SHDR: return t ? T_E1DR : T_SHDR;
            T_E1DR: return t ? T_UDR  : T_PDR;
            T_PDR:  return t ? T_E2DR : T_PDR;
            T_E2DR: return t ? T_UDR  : T_SHDR;
            T_UDR:  return t ? T_SDR  : T_RTI;
            T_SIR:  return t ? T_TLR  : T_CIR;
            T_CIR:  return t ? T_E1IR : T_SHIR;
            T_SHIR: return t ? T_E1IR : T_SHIR;
            T_E1IR: return t ? T_UIR  : T_PIR;
            T_PIR:  return t ? T_E2IR : T_PIR;
            T_E2IR: return t ? T_UIR  : T_SHIR;
            default: return t ? T_SDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        tck_rises <= tck_rises + 1;
        tms_q.push_back(tms);
        case (tap_st)
            T_CDR: begin dr_sh <= dr_cap; nshift <= 0; end
            T_SHDR: begin
                tdi_q.push_back(tdi);
                dr_sh  <= {tdi, dr_sh[31:1]};
                nshift <= nshift + 1;
            end
            T_UDR: begin dr_upd <= dr_sh >> (32 - nshift); upd_cnt <= upd_cnt + 1; end
            T_CIR: ir_sh <= 10'h001;
            T_SHIR: begin tdi_q.push_back(tdi); ir_sh <= {tdi, ir_sh[9:1]}; end
            T_UIR: ir_val <= ir_sh;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        if (tap_st == T_SHDR)      tdo <= dr_sh[0];
        else if (tap_st == T_SHIR) tdo <= ir_sh[0];
    end

    // ---------------- scoreboard and bookkeeping ----------------
    typedef struct {
        logic [31:0] data;
        int          tcks;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;
    int base_rises, base_tms, base_tdi, base_upd;

    function automatic logic [63:0] exp_tms(input bit tlr, input bit ir, input int n);
        logic [63:0] v = '0;
        int k = 0;
        if (tlr) return 64'h1F;
        v[k] = 1'b1; k++;
        if (ir) begin v[k] = 1'b1; k++; end
        v[k] = 1'b0; k++;
        v[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin v[k] = (i == n - 1); k++; end
        v[k] = 1'b1; k++;
        v[k] = 1'b0;
        return v;
    endfunction

    function automatic logic [63:0] got_tms();
        logic [63:0] v = '0;
        for (int i = 0; i < 64 && base_tms + i < tms_q.size(); i++) v[i] = tms_q[base_tms + i];
        return v;
    endfunction

    function automatic logic [31:0] got_tdi();
        logic [31:0] v = '0;
        for (int i = 0; i < 32 && base_tdi + i < tdi_q.size(); i++) v[i] = tdi_q[base_tdi + i];
        return v;
    endfunction

    function automatic logic [31:0] lmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    task automatic send_cmd(input bit tlr, input bit ir, input int len, input logic [31:0] data,
                            input logic [31:0] exp_data, input int exp_tcks, output bit ok);
        int n = 0;
        while (!cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
        ok = cmd_ready;
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_tlr   = tlr;
        cmd_ir    = ir;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        sb.push_back('{exp_data, exp_tcks});
        base_rises = tck_rises;
        base_tms   = tms_q.size();
        base_tdi   = tdi_q.size();
        base_upd   = upd_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_tlr   = ~tlr;
        cmd_ir    = ~ir;
        cmd_len   = '1;
        cmd_data  = ~data;
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        while (!rsp_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
        ok = rsp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n = 0;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (tck !== 1'b0) begin failures++; $display("FAIL reset_tck got=%b exp=0", tck); end
        checks++; if (tms !== 1'b1) begin failures++; $display("FAIL reset_tms got=%b exp=1", tms); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        base_rises = tck_rises;
        base_tms   = tms_q.size();
        rst = 1'b0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 24) begin failures++; $display("FAIL reset_ready_delay got=%0d exp=24", n); end
        checks++; if (tck_rises - base_rises !== 6) begin failures++; $display("FAIL reset_tck_count got=%0d exp=6", tck_rises - base_rises); end
        checks++; if (got_tms() !== 64'h1F) begin failures++; $display("FAIL reset_tms_seq got=%h exp=%h", got_tms(), 64'h1F); end
        checks++; if (tap_st !== T_RTI) begin failures++; $display("FAIL reset_tap_state got=%0d exp=%0d", tap_st, T_RTI); end
    endtask

    task automatic test_dr_scan();
        bit ok; int lat; exp_t e;
        dr_cap = 32'h9E6D_713C;
        send_cmd(0, 0, 8, 32'h0000_00A5, dr_cap & lmask(8), 13, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dr_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL dr_rsp_timeout got=none exp=rsp_valid"); return; end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL dr_rsp_data got=%h exp=%h", rsp_data, e.data); end
        checks++; if (tck_rises - base_rises !== e.tcks) begin failures++; $display("FAIL dr_tck_count got=%0d exp=%0d", tck_rises - base_rises, e.tcks); end
        checks++; if (lat !== TPC * e.tcks + 1) begin failures++; $display("FAIL dr_latency got=%0d exp=%0d", lat, TPC * e.tcks + 1); end
        checks++; if (got_tms() !== exp_tms(0, 0, 8)) begin failures++; $display("FAIL dr_tms_seq got=%h exp=%h", got_tms(), exp_tms(0, 0, 8)); end
        checks++; if (got_tdi() !== 32'hA5) begin failures++; $display("FAIL dr_tdi_seq got=%h exp=%h", got_tdi(), 32'hA5); end
        checks++; if (dr_upd[7:0] !== 8'hA5) begin failures++; $display("FAIL dr_model_update got=%h exp=a5", dr_upd[7:0]); end
        checks++; if (upd_cnt - base_upd !== 1) begin failures++; $display("FAIL dr_update_count got=%0d exp=1", upd_cnt - base_upd); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL dr_ready_at_rsp got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dr_rsp_pulse_width got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL dr_rsp_hold got=%h exp=%h", rsp_data, e.data); end
    endtask

    task automatic test_ir_scan();
        bit ok; int lat; exp_t e;
        send_cmd(0, 1, 10, 32'h0000_03C2, 32'h0000_0001, 16, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ir_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL ir_rsp_timeout got=none exp=rsp_valid"); return; end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL ir_rsp_data got=%h exp=%h", rsp_data, e.data); end
        checks++; if (tck_rises - base_rises !== e.tcks) begin failures++; $display("FAIL ir_tck_count got=%0d exp=%0d", tck_rises - base_rises, e.tcks); end
        checks++; if (lat !== TPC * e.tcks + 1) begin failures++; $display("FAIL ir_latency got=%0d exp=%0d", lat, TPC * e.tcks + 1); end
        checks++; if (got_tms() !== exp_tms(0, 1, 10)) begin failures++; $display("FAIL ir_tms_seq got=%h exp=%h", got_tms(), exp_tms(0, 1, 10)); end
        checks++; if (ir_val !== 10'h3C2) begin failures++; $display("FAIL ir_model_update got=%h exp=3c2", ir_val); end
    endtask

    task automatic test_len_edges();
        bit ok; int lat; exp_t e;
        send_cmd(0, 0, 0, 32'hFFFF_FFFF, 32'h0, 0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL len0_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL len0_latency got=%0d exp=1", lat); end
        checks++; if (tck_rises - base_rises !== e.tcks) begin failures++; $display("FAIL len0_tck_count got=%0d exp=%0d", tck_rises - base_rises, e.tcks); end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL len0_rsp_data got=%h exp=%h", rsp_data, e.data); end
        dr_cap = 32'h0F1E_2D3C;
        send_cmd(0, 0, 40, 32'hDEAD_BEEF, dr_cap, 37, ok);
        checks++; if (!ok) begin failures++; $display("FAIL len40_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL len40_rsp_timeout got=none exp=rsp_valid"); return; end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL len40_rsp_data got=%h exp=%h", rsp_data, e.data); end
        checks++; if (tck_rises - base_rises !== e.tcks) begin failures++; $display("FAIL len40_tck_count got=%0d exp=%0d", tck_rises - base_rises, e.tcks); end
        checks++; if (tdi_q.size() - base_tdi !== 32) begin failures++; $display("FAIL len40_shift_count got=%0d exp=32", tdi_q.size() - base_tdi); end
        checks++; if (dr_upd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL len40_model_update got=%h exp=deadbeef", dr_upd); end
    endtask

    task automatic test_tlr_cmd();
        bit ok; int lat; exp_t e;
        logic [31:0] prev;
        prev = 32'h0F1E_2D3C;
        send_cmd(1, 1, 8, 32'h0000_00FF, prev, 6, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tlr_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL tlr_rsp_timeout got=none exp=rsp_valid"); return; end
        checks++; if (tck_rises - base_rises !== e.tcks) begin failures++; $display("FAIL tlr_tck_count got=%0d exp=%0d", tck_rises - base_rises, e.tcks); end
        checks++; if (got_tms() !== exp_tms(1, 0, 0)) begin failures++; $display("FAIL tlr_tms_seq got=%h exp=%h", got_tms(), exp_tms(1, 0, 0)); end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL tlr_rsp_data_kept got=%h exp=%h", rsp_data, e.data); end
        checks++; if (lat !== TPC * e.tcks + 1) begin failures++; $display("FAIL tlr_latency got=%0d exp=%0d", lat, TPC * e.tcks + 1); end
        checks++; if (tap_st !== T_RTI) begin failures++; $display("FAIL tlr_tap_state got=%0d exp=%0d", tap_st, T_RTI); end
    endtask

    task automatic test_reset_mid_scan();
        bit ok; int lat; exp_t e;
        int n = 0;
        bit seen_rsp = 0;
        logic [31:0] d;
        dr_cap = 32'hCAFE_F00D;
        send_cmd(0, 0, 16, 32'h0000_1234, dr_cap & lmask(16), 21, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_accept got=not_ready exp=ready"); return; end
        while (!(tap_st == T_SHDR && nshift == 5) && n < 500) begin @(posedge clk); #1; n++; end
        checks++; if (n >= 500) begin failures++; $display("FAIL mid_reach_bit5 got=timeout exp=shift_bit5"); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (tck !== 1'b0) begin failures++; $display("FAIL mid_tck_low got=%b exp=0", tck); end
        checks++; if (tms !== 1'b1) begin failures++; $display("FAIL mid_tms_high got=%b exp=1", tms); end
        void'(sb.pop_front());
        repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen_rsp = 1; end
        rst = 1'b0;
        n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; if (rsp_valid) seen_rsp = 1; end
        checks++; if (seen_rsp) begin failures++; $display("FAIL mid_no_rsp got=1 exp=0"); end
        checks++; if (n !== 24) begin failures++; $display("FAIL mid_ready_delay got=%0d exp=24", n); end
        checks++; if (tap_st !== T_RTI) begin failures++; $display("FAIL mid_tap_state got=%0d exp=%0d", tap_st, T_RTI); end
        d = $urandom;
        dr_cap = 32'h1234_5678;
        send_cmd(0, 0, 32, d, dr_cap, 37, ok);
        checks++; if (!ok) begin failures++; $display("FAIL post_accept got=not_ready exp=ready"); return; end
        wait_rsp(lat, ok);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL post_rsp_timeout got=none exp=rsp_valid"); return; end
        checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL post_rsp_data got=%h exp=%h", rsp_data, e.data); end
        checks++; if (dr_upd !== d) begin failures++; $display("FAIL post_model_update got=%h exp=%h", dr_upd, d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_dr_scan();
        test_ir_scan();
        test_len_edges();
        test_tlr_cmd();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
